// File: rtl/past_hist_pkg.sv
// Shared helpers for the sampled-value history: lag port width,
// lag clamping and modular ring indexing for any DEPTH.
package past_hist_pkg;

  // Number of bits needed to express a lag of 0..DEPTH.
  function automatic int lagWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Requested lag mapped onto 1..DEPTH: zero behaves as one, oversize clamps.
  function automatic int effLag(input int lag, input int depth);
    if (lag == 0) begin
      return 1;
    end
    if (lag > depth) begin
      return depth;
    end
    return lag;
  endfunction

  // (ptr - n) mod depth for 0 <= ptr < depth and 1 <= n <= depth,
  // done as a conditional add so DEPTH need not be a power of two.
  function automatic int ringIdx(input int ptr, input int n, input int depth);
    int idx;
    idx = ptr - n;
    if (idx < 0) begin
      idx = idx + depth;
    end
    return idx;
  endfunction

endpackage

// File: rtl/past_hist_ring.sv
// Circular history buffer of DEPTH samples, each NCH*W bits wide.
// Tracks write pointer and fill level and presents the sample that
// sits eff_lag enabled samples behind the write pointer.
module past_hist_ring
  import past_hist_pkg::*;
#(
  parameter int W     = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [NCH*W-1:0] i_din,
  input  logic [LW-1:0]    i_lag,
  output logic [NCH*W-1:0] o_pastVal,
  output logic             o_pastVld
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);

  logic [NCH*W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [FW-1:0]    r_fill;
  logic [PW-1:0]    w_wrIdx;
  logic [PW-1:0]    w_nextPtr;
  logic [PW-1:0]    w_rdIdx;
  int               w_effLag;

  // Flush rewinds the write slot to 0 before a same-edge sample lands.
  always_comb begin
    w_wrIdx   = i_flush ? '0 : r_wrPtr;
    w_nextPtr = (w_wrIdx == PW'(DEPTH - 1)) ? '0 : w_wrIdx + PW'(1);
  end

  // Pointer and fill bookkeeping; fill saturates once the ring is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
    end else if (i_flush) begin
      r_wrPtr <= i_en ? w_nextPtr : '0;
      r_fill  <= i_en ? FW'(1) : '0;
    end else if (i_en) begin
      r_wrPtr <= w_nextPtr;
      if (r_fill != FW'(DEPTH)) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

  // Sample storage; contents are meaningless until covered by fill, so no reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[w_wrIdx] <= i_din;
    end
  end

  // Read side is purely combinational so a lag change is seen immediately.
  always_comb begin
    w_effLag  = effLag(int'(i_lag), DEPTH);
    w_rdIdx   = PW'(ringIdx(int'(r_wrPtr), w_effLag, DEPTH));
    o_pastVld = (int'(r_fill) >= w_effLag);
    o_pastVal = o_pastVld ? r_mem[w_rdIdx] : '0;
  end

endmodule

// File: rtl/past_sample_history.sv
// Multi-channel $past()-style history with runtime lag, sample gating
// and a per-channel delta checker with a saturating mismatch counter.
module past_sample_history
  import past_hist_pkg::*;
#(
  parameter int W     = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic [NCH*W-1:0]            din,
  input  logic [lagWidth(DEPTH)-1:0]  lag,
  input  logic [W-1:0]                exp_delta,
  input  logic                        chk_en,
  output logic [NCH*W-1:0]            past_val,
  output logic                        past_vld,
  output logic [NCH*W-1:0]            delta,
  output logic [NCH-1:0]              mismatch,
  output logic [CNTW-1:0]             err_cnt
);

  logic [NCH*W-1:0] w_pastVal;
  logic             w_pastVld;
  logic [NCH*W-1:0] w_delta;
  logic [NCH-1:0]   w_miss;
  logic [NCH-1:0]   r_mismatch;
  logic [CNTW-1:0]  r_errCnt;

  past_hist_ring #(
    .W     (W),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .LW    (lagWidth(DEPTH))
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .i_en      (en),
    .i_flush   (flush),
    .i_din     (din),
    .i_lag     (lag),
    .o_pastVal (w_pastVal),
    .o_pastVld (w_pastVld)
  );

  // Per-channel wrapping difference and its comparison to the expected step.
  always_comb begin
    w_delta = '0;
    w_miss  = '0;
    for (int c = 0; c < NCH; c++) begin
      w_delta[c*W +: W] = din[c*W +: W] - w_pastVal[c*W +: W];
      w_miss[c]         = (w_delta[c*W +: W] != exp_delta);
    end
  end

  // Checker registers act on pre-edge history; idle edges clear the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= '0;
      r_errCnt   <= '0;
    end else if (chk_en && w_pastVld) begin
      r_mismatch <= w_miss;
      if ((|w_miss) && (r_errCnt != '1)) begin
        r_errCnt <= r_errCnt + CNTW'(1);
      end
    end else begin
      r_mismatch <= '0;
    end
  end

  assign past_val = w_pastVal;
  assign past_vld = w_pastVld;
  assign delta    = w_delta;
  assign mismatch = r_mismatch;
  assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_past_sample_history.sv
// Randomised and directed bench for past_sample_history, checked against
// a queue-based history model (newest sample at the front).
module tb_past_sample_history;

  localparam int W     = 8;
  localparam int NCH   = 2;
  localparam int DEPTH = 5;
  localparam int CNTW  = 3;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [NCH*W-1:0] din;
  logic [LW-1:0]    lag;
  logic [W-1:0]     exp_delta;
  logic             chk_en;
  logic [NCH*W-1:0] past_val;
  logic             past_vld;
  logic [NCH*W-1:0] delta;
  logic [NCH-1:0]   mismatch;
  logic [CNTW-1:0]  err_cnt;

  logic [NCH*W-1:0] hist[$];
  logic [NCH-1:0]   mMiss;
  int               mErr;
  int               checks;
  int               errors;

  past_sample_history #(
    .W     (W),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .din       (din),
    .lag       (lag),
    .exp_delta (exp_delta),
    .chk_en    (chk_en),
    .past_val  (past_val),
    .past_vld  (past_vld),
    .delta     (delta),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelLag(input int l);
    if (l == 0) return 1;
    if (l > DEPTH) return DEPTH;
    return l;
  endfunction

  function automatic logic modelVld();
    return hist.size() >= modelLag(int'(lag));
  endfunction

  function automatic logic [NCH*W-1:0] modelPast();
    if (!modelVld()) return '0;
    return hist[modelLag(int'(lag)) - 1];
  endfunction

  function automatic logic [NCH*W-1:0] modelDelta();
    logic [NCH*W-1:0] pv;
    logic [NCH*W-1:0] d;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    pv = modelPast();
    d  = '0;
    for (int c = 0; c < NCH; c++) begin
      a = din[c*W +: W];
      b = pv[c*W +: W];
      d[c*W +: W] = a - b;
    end
    return d;
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".past_vld"}, 64'(past_vld), 64'(modelVld()));
    checkOutput({tag, ".past_val"}, 64'(past_val), 64'(modelPast()));
    checkOutput({tag, ".delta"}, 64'(delta), 64'(modelDelta()));
    checkOutput({tag, ".mismatch"}, 64'(mismatch), 64'(mMiss));
    checkOutput({tag, ".err_cnt"}, 64'(err_cnt), 64'(mErr));
  endtask

  task automatic modelUpdate();
    logic [NCH*W-1:0] d;
    d = modelDelta();
    if (chk_en && modelVld()) begin
      for (int c = 0; c < NCH; c++) begin
        mMiss[c] = (d[c*W +: W] != exp_delta);
      end
      if ((|mMiss) && (mErr < (2 ** CNTW) - 1)) mErr++;
    end else begin
      mMiss = '0;
    end
    if (flush) hist.delete();
    if (en) begin
      hist.push_front(din);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic applyStimulus(input logic e, input logic f, input logic [W-1:0] c0,
                               input logic [W-1:0] c1, input logic [LW-1:0] l,
                               input logic [W-1:0] ed, input logic ck);
    en        = e;
    flush     = f;
    din       = {c1, c0};
    lag       = l;
    exp_delta = ed;
    chk_en    = ck;
  endtask

  task automatic stepClock(input string tag);
    @(negedge clk);
    compareAll(tag);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    hist.delete();
    mMiss = '0;
    mErr  = 0;
    #1;
    compareAll(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    checks = 0;
    errors = 0;
    mMiss  = '0;
    mErr   = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, LW'(1), 8'h01, 1'b0);
    #1;
    compareAll("init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ramp: ch0 steps by 1, ch1 by 3; ch1 always mismatches, counter saturates.
    for (int cyc = 0; cyc < 12; cyc++) begin
      applyStimulus(1'b1, 1'b0, 8'(cyc), 8'(3 * cyc), LW'(1), 8'h01, 1'b1);
      stepClock("ramp");
    end

    // Lag sweep over a full ring, including lag 0 and oversize lags.
    for (int l = 0; l < (1 << LW); l++) begin
      applyStimulus(1'b0, 1'b0, 8'h20, 8'h30, LW'(l), 8'h02, 1'b1);
      stepClock("lagsweep");
    end

    // Flush together with a sample, then a flush with a pre-flush check.
    applyStimulus(1'b1, 1'b1, 8'h40, 8'h41, LW'(1), 8'h01, 1'b1);
    stepClock("flush");
    applyStimulus(1'b0, 1'b0, 8'h42, 8'h43, LW'(1), 8'h02, 1'b1);
    stepClock("flush.lag1");
    applyStimulus(1'b0, 1'b0, 8'h42, 8'h43, LW'(2), 8'h02, 1'b1);
    stepClock("flush.lag2");
    applyStimulus(1'b0, 1'b1, 8'h44, 8'h45, LW'(1), 8'h04, 1'b1);
    stepClock("flush.chk");
    applyStimulus(1'b0, 1'b0, 8'h44, 8'h45, LW'(1), 8'h04, 1'b1);
    stepClock("flush.empty");

    // Sampling only on even cycles with a mid-run asynchronous reset.
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc == 5) doReset("midrst");
      if (cyc == 6 || cyc == 7) begin
        applyStimulus(1'b0, 1'b0, 8'(cyc), 8'(cyc), LW'(1), 8'h01, 1'b1);
      end else begin
        applyStimulus(cyc % 2 == 0, 1'b0, 8'(cyc), 8'(cyc), LW'(1), 8'h01, 1'b1);
      end
      stepClock("even");
    end

    doReset("rst2");

    // Random traffic: mostly small steps so matches and mismatches both occur.
    r0 = 8'h00;
    r1 = 8'h80;
    for (int i = 0; i < 300; i++) begin
      r0 = r0 + 8'($urandom_range(0, 3));
      r1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : r1 + 8'($urandom_range(0, 2));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, r0, r1,
                    LW'($urandom_range(0, (1 << LW) - 1)), 8'($urandom_range(0, 4)),
                    $urandom_range(0, 3) != 0);
      stepClock("rand");
      if (i == 150) doReset("rst3");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/past_sample_history.md
Name: past_sample_history

Overview:
- Multi-channel sampled-value history. Hardware counterpart of `$past(expr, ticks, gate, @(posedge clk))`, generalised in three ways: runtime-selectable lag, per-sample gating, and a built-in delta checker.
- Captures NCH channels of W-bit data on enabled clock edges into a circular buffer of DEPTH samples.
- Presents each channel's value from `lag` enabled samples ago, with a validity flag.
- Optionally checks that the current-minus-past delta equals an expected step and counts mismatches.
- Sits beside assertion/monitor logic in test benches and debug fabric.

Parameters:
- W, 8, data width per channel (>=1)
- NCH, 2, number of channels (>=1)
- DEPTH, 8, maximum history depth in samples (>=1; need not be a power of two)
- CNTW, 16, width of mismatch counter

Ports:
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  sampling gate (expression2 of `$past`); sample taken only on edges where en=1
- flush  in  1  synchronous history clear
- din  in  NCH*W  current values, channel c at [c*W +: W]
- lag  in  $clog2(DEPTH+1)  requested ticks back
- exp_delta  in  W  expected (din - past) per channel, shared across channels
- chk_en  in  1  enable delta check this edge
- past_val  out  NCH*W  value `lag` samples ago, per channel
- past_vld  out  1  history holds at least eff_lag samples
- delta  out  NCH*W  din - past_val per channel, modulo 2^W
- mismatch  out  NCH  registered per-channel mismatch from last checked edge
- err_cnt  out  CNTW  total mismatching edges, saturating

Behaviour:
- Reset (async, any time, including mid-operation):
  - wr_ptr=0, fill=0, mismatch=0, err_cnt=0.
  - Buffer contents need not be cleared; past_val is forced to 0 while past_vld=0.
- eff_lag rule:
  - lag=0 → eff_lag=1.
  - lag>DEPTH → eff_lag=DEPTH.
  - otherwise eff_lag=lag.
- Sampling, on posedge with en=1:
  - mem[wr_ptr] <= din.
  - wr_ptr advances by 1, wrapping DEPTH-1 → 0.
  - fill saturates at DEPTH.
- Sampling with en=0: mem, wr_ptr and fill all hold.
- flush=1: fill <= 0 and wr_ptr <= 0. If en=1 on the same edge, that sample is written to mem[0] and fill becomes 1, i.e. flush applies first.
- Read path is combinational from registered state:
  - rd_idx = (wr_ptr - eff_lag) mod DEPTH.
  - past_vld = (fill >= eff_lag).
  - past_val = past_vld ? mem[rd_idx] : 0.
  - Latency: a sample written on edge k is visible as eff_lag=1 history in the cycle after edge k.
- delta: combinational, din - past_val per channel, truncated to W bits (wraps).
- Check, on posedge with chk_en=1 and past_vld=1:
  - mismatch[c] <= (delta_c != exp_delta).
  - err_cnt increments by 1 if any bit is set, saturating at 2^CNTW-1.
- Check with chk_en=0 or past_vld=0: mismatch <= 0 and err_cnt holds.
- The check uses pre-edge values of past_val. A simultaneous en sample affects the next cycle only.
- flush and chk_en on the same edge: the check uses pre-flush state.
- A lag change takes effect combinationally in the same cycle; no history is lost.

Decomposition:
- Shared package past_hist_pkg holds:
  - the lag width function clog2(DEPTH+1)
  - the eff_lag clamp function
  - the modular index helper (ptr - n) mod DEPTH for non-power-of-two DEPTH
- One natural sub-module, past_hist_ring: single circular buffer of DEPTH x (NCH*W) with wr_ptr, fill and read index.
- The top level adds the delta, checker and counter logic.

Test Plan:
- W=8, NCH=1, DEPTH=8, en=1 always, din=cyc (0,1,2,...), lag=1, exp_delta=1, chk_en=1 → past_vld low in cycle 0 and high from cycle 1; past_val=din-1 thereafter; err_cnt stays 0 through cyc=10.
- Same stimulus, en high only on even cycles → past_val updates every two cycles; delta toggles between 1 and 2; with chk_en=1, err_cnt increments on cycles where delta=2.
- DEPTH=4, din increments by 1, lag=4 → past_val=din-4 after 4 samples. With lag=7 (clamped to 4) the output is identical; with lag=0 it behaves as lag=1. wr_ptr wraps 3→0 without glitch.
- NCH=2, ch0 increments by 1 and ch1 by 3, exp_delta=1 → mismatch=2'b10 on every checked edge; err_cnt counts 1 per edge.
- Assert rst for 1 cycle mid-run at cyc=5 → outputs go to 0 immediately (async); past_vld stays low until the first enabled sample after deassertion.
- Assert flush together with en at din=0x40 → next cycle fill=1, past_val=0x40 with lag=1, past_vld=0 with lag=2; CNTW=2 saturation: after 5 mismatching edges, err_cnt=3.
